// File: rtl/wide_add_pkg.sv
// Shared types and default widths for the slice-serial wide adder.
package wide_add_pkg;

  localparam int DEF_TOTALBITS = 32;
  localparam int DEF_NUMBITS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_sequencer_cla.sv
// N-bit carry-lookahead adder: every carry is a flat sum of generate/propagate
// products, so there is no ripple chain through the slice.
module nBitCarryLookAheadAdder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  // Carry into bit k = g[k-1] | p[k-1]g[k-2] | ... | p[k-1..0]cin.
  function automatic logic lookahead(input logic [N-1:0] gi, input logic [N-1:0] pi,
                                     input logic ci, input int k);
    logic r;
    logic t;
    r = 1'b0;
    for (int j = 0; j < k; j++) begin
      t = gi[j];
      for (int m = j + 1; m < k; m++) t = t & pi[m];
      r = r | t;
    end
    t = ci;
    for (int m = 0; m < k; m++) t = t & pi[m];
    return r | t;
  endfunction

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 1; k <= N; k++) begin : g_carry
    assign c[k] = lookahead(g, p, cin, k);
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Slice-serial wide adder: one NUMBITS-wide CLA reused over NSLICE cycles.
// Optional macro WIDE_ADD_OVF_EN adds a signed-overflow output (ovf).
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int TOTALBITS = DEF_TOTALBITS,
  parameter int NUMBITS   = DEF_NUMBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TOTALBITS-1:0] a_in,
  input  logic [TOTALBITS-1:0] b_in,
  input  logic                 c_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TOTALBITS-1:0] s_out,
  output logic                 c_out,
  output logic                 busy
`ifdef WIDE_ADD_OVF_EN
  ,output logic                ovf
`endif
);

  localparam int NSLICE = TOTALBITS / NUMBITS;
  localparam int CW     = $clog2(NSLICE);

  state_t               state, state_nxt;
  logic [TOTALBITS-1:0] a_q, b_q, acc_q, s_q;
  logic                 carry_q, c_q, rsp_vld_q;
  logic [CW-1:0]        cnt;
  logic [NUMBITS-1:0]   sum_sl;
  logic                 co_sl;
  logic                 accept, last, handshake;

  nBitCarryLookAheadAdder #(.N(NUMBITS)) u_slice (
    .a    (a_q[NUMBITS-1:0]),
    .b    (b_q[NUMBITS-1:0]),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (co_sl)
  );

  assign accept    = (state == ST_IDLE) && req_valid;
  assign last      = (state == ST_RUN) && (cnt == CW'(NSLICE - 1));
  assign handshake = (state == ST_DONE) && rsp_vld_q && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (handshake) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = rsp_vld_q;
  end

  // Slice datapath: operands drain from the LSB end, sums fill acc from the MSB end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= c_in;
      cnt     <= '0;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> NUMBITS;
      b_q     <= b_q >> NUMBITS;
      acc_q   <= {sum_sl, acc_q[TOTALBITS-1:NUMBITS]};
      carry_q <= co_sl;
      cnt     <= cnt + CW'(1);
    end
  end

  // Result registers change only on the final slice, so they hold outside DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (last) begin
      s_q <= {sum_sl, acc_q[TOTALBITS-1:NUMBITS]};
      c_q <= co_sl;
    end
  end

  // Result is published the cycle after DONE is entered and drops on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_vld_q <= 1'b0;
    else       rsp_vld_q <= (state == ST_DONE) && !handshake;
  end

  assign s_out = s_q;
  assign c_out = c_q;

`ifdef WIDE_ADD_OVF_EN
  logic ovf_q;
  // Carry into the word MSB is recovered from the top slice bit: s ^ a ^ b.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ovf_q <= 1'b0;
    else if (last) ovf_q <= (sum_sl[NUMBITS-1] ^ a_q[NUMBITS-1] ^ b_q[NUMBITS-1]) ^ co_sl;
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (32/4): latency, hold, reset abort, noise.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        c_in = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] s_out;
  logic        c_out;
  logic        busy;
`ifdef WIDE_ADD_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  wide_add_sequencer #(.TOTALBITS(32), .NUMBITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .s_out     (s_out),
    .c_out     (c_out),
    .busy      (busy)
`ifdef WIDE_ADD_OVF_EN
    ,.ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request; expected sum from a 33-bit reference add. noise keeps req_valid
  // high with other operands while busy, which the DUT must ignore.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input int hold, input bit noise);
    logic [32:0] exp;
    int          lat;
    bit          stable;
    bit          rdy_low;
    exp = {1'b0, a} + {1'b0, b} + 33'(ci);
    lat = 0;
    while (!req_ready && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, ".idle"}, 64'(req_ready), 64'd1);
    a_in = a; b_in = b; c_in = ci; req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    if (noise) begin a_in = ~a; b_in = a ^ b; c_in = ~ci; end
    else req_valid = 1'b0;
    lat = 0; rdy_low = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) rdy_low = 1'b0;
      @(negedge clk); lat++;
    end
    req_valid = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'd9);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (s_out !== exp[31:0] || c_out !== exp[32] || !rsp_valid || req_ready) stable = 1'b0;
      @(negedge clk);
    end
    chk({tag, ".s"}, 64'(s_out), 64'(exp[31:0]));
    chk({tag, ".c"}, 64'(c_out), 64'(exp[32]));
    chk({tag, ".hold"}, 64'(stable), 64'd1);
    chk({tag, ".rdy_low"}, 64'(rdy_low), 64'd1);
`ifdef WIDE_ADD_OVF_EN
    chk({tag, ".ovf"}, 64'(ovf), 64'((a[31] == b[31]) && (exp[31] != a[31])));
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    bit seen;
    @(negedge clk);
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.busy",  64'(busy),      64'd0);
    chk("rst.s",     64'(s_out),     64'd0);
    chk("rst.c",     64'(c_out),     64'd0);
`ifdef WIDE_ADD_OVF_EN
    chk("rst.ovf",   64'(ovf),       64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("allones", 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
    run_op("hold5", 32'h1234_5678, 32'h0FED_CBA8, 1'b0, 5, 1'b0);
    run_op("noise", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 2, 1'b1);
    run_op("zero", 32'h0, 32'h0, 1'b0, 0, 1'b0);

    // Abort mid-RUN: after three RUN cycles, no response may ever appear.
    a_in = 32'hAAAA_AAAA; b_in = 32'h5555_5555; c_in = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort.ready", 64'(req_ready), 64'd1);
    chk("abort.busy",  64'(busy),      64'd0);
    chk("abort.s",     64'(s_out),     64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("abort.no_rsp", 64'(seen), 64'd0);
    run_op("after_abort", 32'd5, 32'd7, 1'b0, 1, 1'b0);

`ifdef WIDE_ADD_OVF_EN
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1, 1'b0);
    run_op("ovf_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 1'b0);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
`endif

    for (int n = 0; n < 1000; n++)
      run_op("rnd", $urandom, $urandom, 1'($urandom % 2), int'($urandom_range(0, 2)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
